mul1024_operand_loader: RTL and testbench

Upstream feeder for the 1024-bit combinational multiplier `mul1024`. It accepts operands as a stream of 32-bit words over a valid/ready handshake and assembles them into two 1024-bit registers, `a` and `b`. Once both are complete it holds them stable with `op_valid` high, so the multiplier output `p` can be sampled by the downstream consumer. The consumer releases the operands with `op_ack`, and loading restarts.

---
 rtl/mul1024_operand_loader_pkg.sv | 16 +
 rtl/mul1024_operand_loader_word_assembler.sv | 33 +++
 rtl/mul1024_operand_loader.sv | 125 ++++++++++++
 tb/tb_mul1024_operand_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul1024_operand_loader_pkg.sv
// Shared definitions for the 1024-bit multiplier datapath.
// Holds the stream/operand geometry and the loader state encoding.
// The planned downstream product serializer reuses these definitions.
package mul_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 1024;
    localparam int unsigned NWORDS = OP_W / WORD_W;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } load_state_t;

endpackage

// File: rtl/mul1024_operand_loader_word_assembler.sv
// word_assembler: builds one OP_W operand register from WORD_W slices.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear to zero (wins over wr_en)
//   wr_en     - write data into slot idx this edge
//   idx       - word slot index, 0 = least-significant word
//   data      - word to insert
//   value     - assembled operand
module word_assembler #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 1024,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] data,
    output logic [OP_W-1:0]   value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (wr_en) begin
            value[32'(idx) * WORD_W +: WORD_W] <= data;
        end
    end

endmodule

// File: rtl/mul1024_operand_loader.sv
// mul1024_operand_loader: collects two OP_W operands from a WORD_W
// valid/ready stream (A words first, then B, least-significant word first)
// and holds them stable for the combinational multiplier until op_ack.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - word handshake; in_ready depends only on state
//   in_data           - operand word
//   flush             - synchronous abort, clears operands, back to LOAD_A
//   a, b              - operands to the multiplier
//   op_valid          - a and b complete and frozen
//   op_ack            - consumer done with the product, release operands
module mul1024_operand_loader
    import mul_pkg::*;
#(
    parameter int unsigned WORD_W = mul_pkg::WORD_W,
    parameter int unsigned OP_W   = mul_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              flush,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    output logic              op_valid,
    input  logic              op_ack
);

    localparam int unsigned NW    = OP_W / WORD_W;
    localparam int unsigned CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NW - 1);

    load_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_word;

    assign accept    = in_valid && in_ready;
    assign last_word = (cnt == LAST);

    // in_ready and op_valid are registered alongside the state so they
    // are glitch-free functions of state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD_A;
            cnt      <= '0;
            in_ready <= 1'b1;
            op_valid <= 1'b0;
        end else if (flush) begin
            state    <= LOAD_A;
            cnt      <= '0;
            in_ready <= 1'b1;
            op_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (last_word) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (last_word) begin
                            cnt      <= '0;
                            state    <= HOLD;
                            in_ready <= 1'b0;
                            op_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (op_ack) begin
                        state    <= LOAD_A;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        op_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD_A;
                    cnt      <= '0;
                    in_ready <= 1'b1;
                    op_valid <= 1'b0;
                end
            endcase
        end
    end

    word_assembler #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .IDX_W  (CNT_W)
    ) u_asm_a (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .wr_en (accept && (state == LOAD_A)),
        .idx   (cnt),
        .data  (in_data),
        .value (a)
    );

    word_assembler #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .IDX_W  (CNT_W)
    ) u_asm_b (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .wr_en (accept && (state == LOAD_B)),
        .idx   (cnt),
        .data  (in_data),
        .value (b)
    );

endmodule

// File: tb/tb_mul1024_operand_loader.sv
// Bench for mul1024_operand_loader: random/directed streams against a
// word-count based model of the loader, plus literal product checks.
module tb_mul1024_operand_loader;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 1024;
    localparam int unsigned NW     = OP_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              op_valid;
    logic              op_ack = 1'b0;

    logic [2*OP_W-1:0] p;
    assign p = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mul1024_operand_loader #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .op_valid (op_valid),
        .op_ack   (op_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*OP_W-1:0] got,
                         input logic [2*OP_W-1:0] exp);
        int unsigned w;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            w = 0;
            for (int unsigned i = 0; i < 2*OP_W/32; i++) begin
                if (got[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    w = i;
                    break;
                end
            end
            $display("FAIL %s: got low64=%h want low64=%h (first differing 32b word %0d: got %h want %h) t=%0t",
                     name, got[63:0], exp[63:0], w, got[w*32 +: 32], exp[w*32 +: 32], $time);
        end
    endtask

    // Model: the loader is described purely by how many words it has
    // accepted since the last release (0..2*NW); word k lands in A for
    // k < NW, in B otherwise; 2*NW means operands are held.
    int unsigned     mn = 0;
    logic [OP_W-1:0] ma = '0;
    logic [OP_W-1:0] mb = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mn = 0; ma = '0; mb = '0;
        end else if (flush) begin
            mn = 0; ma = '0; mb = '0;
        end else if (mn < 2*NW) begin
            if (in_valid) begin
                if (mn < NW) ma[mn*WORD_W +: WORD_W] = in_data;
                else         mb[(mn-NW)*WORD_W +: WORD_W] = in_data;
                mn++;
            end
        end else if (op_ack) begin
            mn = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 2048'(in_ready), 2048'(mn < 2*NW));
            check("op_valid", 2048'(op_valid), 2048'(mn == 2*NW));
            check("a", 2048'(a), 2048'(ma));
            check("b", 2048'(b), 2048'(mb));
        end
    end

    logic [WORD_W-1:0] wq[$];

    task automatic push_op(input logic [OP_W-1:0] v);
        for (int unsigned i = 0; i < NW; i++) wq.push_back(v[i*WORD_W +: WORD_W]);
    endtask

    task automatic push_rand(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // Streams words from wq until target accepts or max_cyc edges elapse.
    task automatic drive(input int unsigned target, input int unsigned gap_pct,
                         input bit auto_ack, input int unsigned max_cyc,
                         output int unsigned cyc);
        int unsigned got;
        bit acc;
        cyc = 0;
        got = 0;
        while (got < target && wq.size() > 0 && cyc < max_cyc) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = wq[0];
            op_ack   = auto_ack && op_valid;
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                void'(wq.pop_front());
                got++;
            end
        end
        in_valid = 1'b0;
        op_ack   = 1'b0;
        check("drive_accepts", 2048'(got), 2048'(target));
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    logic [OP_W-1:0]   v3423, v434;
    logic [2*OP_W-1:0] p_ones, one2k;
    int unsigned       cyc;

    initial begin
        v3423 = OP_W'(3423);
        v434  = OP_W'(434);
        one2k = 2048'(1);
        p_ones = 2048'(0) - (one2k << 1025) + one2k;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 2048'(in_ready), 2048'(1));
        check("rst_op_valid", 2048'(op_valid), 2048'(0));
        check("rst_a", 2048'(a), 2048'(0));
        check("rst_b", 2048'(b), 2048'(0));

        // 3423 x 434, back-to-back
        push_op(v3423); push_op(v434);
        drive(2*NW, 0, 1'b0, 200, cyc);
        check("latency_edges", 2048'(cyc), 2048'(64));
        check("hold_op_valid", 2048'(op_valid), 2048'(1));
        check("hold_in_ready", 2048'(in_ready), 2048'(0));
        check("p_3423x434", p, 2048'(1485582));
        step();
        check("still_held", 2048'(in_ready), 2048'(0));
        op_ack = 1'b1; step(); op_ack = 1'b0;
        check("ack_in_ready", 2048'(in_ready), 2048'(1));
        check("ack_op_valid", 2048'(op_valid), 2048'(0));

        // all-ones with random gaps
        push_op('1); push_op('1);
        drive(2*NW, 40, 1'b0, 2000, cyc);
        check("ones_op_valid", 2048'(op_valid), 2048'(1));
        check("p_ones", p, p_ones);

        // hold 10 cycles, in_valid ignored
        for (int unsigned i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        check("hold_a", 2048'(a), 2048'({OP_W{1'b1}}));
        check("hold_b", 2048'(b), 2048'({OP_W{1'b1}}));
        check("hold_p", p, p_ones);

        // half-cycle asynchronous reset in HOLD
        #1 rst = 1'b1;
        #2;
        check("arst_op_valid", 2048'(op_valid), 2048'(0));
        check("arst_a", 2048'(a), 2048'(0));
        check("arst_b", 2048'(b), 2048'(0));
        check("arst_in_ready", 2048'(in_ready), 2048'(1));
        rst = 1'b0;
        step();
        op_ack = 1'b1; step(); op_ack = 1'b0;
        check("stray_ack_ready", 2048'(in_ready), 2048'(1));
        check("stray_ack_valid", 2048'(op_valid), 2048'(0));

        // flush after 40 words, together with a valid word
        push_rand(64);
        drive(40, 0, 1'b0, 200, cyc);
        wq.delete();
        in_valid = 1'b1; in_data = $urandom; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_a", 2048'(a), 2048'(0));
        check("flush_b", 2048'(b), 2048'(0));
        check("flush_in_ready", 2048'(in_ready), 2048'(1));
        push_op(v3423); push_op(v434);
        drive(2*NW, 0, 1'b0, 200, cyc);
        check("reload_latency", 2048'(cyc), 2048'(64));
        check("p_after_flush", p, 2048'(1485582));

        // op_ack and flush together in HOLD
        op_ack = 1'b1; flush = 1'b1;
        step();
        op_ack = 1'b0; flush = 1'b0;
        check("ackflush_a", 2048'(a), 2048'(0));
        check("ackflush_b", 2048'(b), 2048'(0));
        check("ackflush_op_valid", 2048'(op_valid), 2048'(0));

        // back-to-back products, ack in the cycle after each op_valid
        push_rand(3*2*NW);
        drive(3*2*NW, 0, 1'b1, 600, cyc);
        check("b2b_cycles", 2048'(cyc), 2048'(2*65 + 64));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
